// File: rtl/fsm_led_seq_driver_pkg.sv
// Shared encodings for the LED switch-code sequencer: target/led state codes, sw hop codes, driver FSM states.
// Pure declarations; no latency or flow control of its own.
package fsm_led_seq_driver_pkg;

    typedef enum logic [1:0] {
        TGT_IDLE  = 2'b00,
        TGT_LED01 = 2'b01,
        TGT_LED02 = 2'b10,
        TGT_BAD   = 2'b11
    } tgt_t;

    // Downstream led output swaps the two LED bits relative to the target encoding.
    localparam logic [1:0] LED_IDLE  = 2'b00;
    localparam logic [1:0] LED_LED01 = 2'b10;
    localparam logic [1:0] LED_LED02 = 2'b01;

    localparam logic [2:0] SW_NEUTRAL     = 3'b000;
    localparam logic [2:0] SW_IDLE_TO_L01 = 3'b001;
    localparam logic [2:0] SW_L01_TO_L02  = 3'b011;
    localparam logic [2:0] SW_L02_TO_L01  = 3'b110;
    localparam logic [2:0] SW_L02_TO_IDLE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } drv_state_t;

    function automatic tgt_t led_to_tgt(input logic [1:0] led);
        tgt_t t;
        case (led)
            LED_IDLE:  t = TGT_IDLE;
            LED_LED01: t = TGT_LED01;
            LED_LED02: t = TGT_LED02;
            default:   t = TGT_BAD;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fsm_led_path_lut.sv
// Maps (current, target) state to up to two sw hops with their expected led feedback.
// Purely combinational, zero latency, no flow control.
module fsm_led_path_lut
    import fsm_led_seq_driver_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [1:0] tgt,
    output logic [2:0] hop1_code,
    output logic [1:0] hop1_exp,
    output logic [2:0] hop2_code,
    output logic [1:0] hop2_exp,
    output logic       two_hop,
    output logic       same,
    output logic       illegal
);

    always_comb begin
        hop1_code = SW_NEUTRAL;
        hop1_exp  = LED_IDLE;
        hop2_code = SW_NEUTRAL;
        hop2_exp  = LED_IDLE;
        two_hop   = 1'b0;
        illegal   = (cur == TGT_BAD) || (tgt == TGT_BAD);
        same      = !illegal && (cur == tgt);
        case ({cur, tgt})
            {TGT_IDLE, TGT_LED01}: begin
                hop1_code = SW_IDLE_TO_L01;
                hop1_exp  = LED_LED01;
            end
            {TGT_IDLE, TGT_LED02}: begin
                hop1_code = SW_IDLE_TO_L01;
                hop1_exp  = LED_LED01;
                hop2_code = SW_L01_TO_L02;
                hop2_exp  = LED_LED02;
                two_hop   = 1'b1;
            end
            {TGT_LED01, TGT_LED02}: begin
                hop1_code = SW_L01_TO_L02;
                hop1_exp  = LED_LED02;
            end
            // No direct LED01->IDLE code exists, so route through LED02.
            {TGT_LED01, TGT_IDLE}: begin
                hop1_code = SW_L01_TO_L02;
                hop1_exp  = LED_LED02;
                hop2_code = SW_L02_TO_IDLE;
                hop2_exp  = LED_IDLE;
                two_hop   = 1'b1;
            end
            {TGT_LED02, TGT_LED01}: begin
                hop1_code = SW_L02_TO_L01;
                hop1_exp  = LED_LED01;
            end
            {TGT_LED02, TGT_IDLE}: begin
                hop1_code = SW_L02_TO_IDLE;
                hop1_exp  = LED_IDLE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fsm_led_seq_driver.sv
// Walks the downstream LED FSM to a requested state with held sw hop codes; done/err pulse at the end.
// Latency HOLD_CYC+2 cycles for one hop (+HOLD_CYC+1 per extra hop); req_ready low while busy, requests then are dropped.
module fsm_led_seq_driver
    import fsm_led_seq_driver_pkg::*;
#(
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    output logic       req_ready,
    input  logic [1:0] led_fb,
    output logic [2:0] sw,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] cur_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       sw_q, sw_d;
    logic [1:0]       cur_state_q, cur_state_d;
    logic [2:0]       hop1_code_q, hop1_code_d, hop2_code_q, hop2_code_d;
    logic [1:0]       hop1_exp_q, hop1_exp_d, hop2_exp_q, hop2_exp_d;
    logic             two_hop_q, two_hop_d, second_q, second_d;

    tgt_t       fb_tgt;
    logic [2:0] lut_hop1_code, lut_hop2_code;
    logic [1:0] lut_hop1_exp, lut_hop2_exp;
    logic       lut_two_hop, lut_same, lut_illegal;
    logic [1:0] wait_exp;

    assign fb_tgt = led_to_tgt(led_fb);

    fsm_led_path_lut u_lut (
        .cur       (fb_tgt),
        .tgt       (req_target),
        .hop1_code (lut_hop1_code),
        .hop1_exp  (lut_hop1_exp),
        .hop2_code (lut_hop2_code),
        .hop2_exp  (lut_hop2_exp),
        .two_hop   (lut_two_hop),
        .same      (lut_same),
        .illegal   (lut_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sw_q        <= SW_NEUTRAL;
            cur_state_q <= TGT_IDLE;
            hop1_code_q <= SW_NEUTRAL;
            hop2_code_q <= SW_NEUTRAL;
            hop1_exp_q  <= LED_IDLE;
            hop2_exp_q  <= LED_IDLE;
            two_hop_q   <= 1'b0;
            second_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_q        <= sw_d;
            cur_state_q <= cur_state_d;
            hop1_code_q <= hop1_code_d;
            hop2_code_q <= hop2_code_d;
            hop1_exp_q  <= hop1_exp_d;
            hop2_exp_q  <= hop2_exp_d;
            two_hop_q   <= two_hop_d;
            second_q    <= second_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sw_d        = SW_NEUTRAL;
        hop1_code_d = hop1_code_q;
        hop2_code_d = hop2_code_q;
        hop1_exp_d  = hop1_exp_q;
        hop2_exp_d  = hop2_exp_q;
        two_hop_d   = two_hop_q;
        second_d    = second_q;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        wait_exp    = second_q ? hop2_exp_q : hop1_exp_q;
        // An invalid led code keeps the last good decode rather than reporting 11.
        cur_state_d = (fb_tgt == TGT_BAD) ? cur_state_q : fb_tgt;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (lut_illegal) begin
                        state_d = S_ERR;
                    end else if (lut_same) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_DRIVE;
                        hop1_code_d = lut_hop1_code;
                        hop2_code_d = lut_hop2_code;
                        hop1_exp_d  = lut_hop1_exp;
                        hop2_exp_d  = lut_hop2_exp;
                        two_hop_d   = lut_two_hop;
                        second_d    = 1'b0;
                        sw_d        = lut_hop1_code;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    sw_d  = second_q ? hop2_code_q : hop1_code_q;
                end
            end
            S_WAIT: begin
                if (led_fb == wait_exp) begin
                    if (two_hop_q && !second_q) begin
                        state_d  = S_DRIVE;
                        second_d = 1'b1;
                        cnt_d    = '0;
                        sw_d     = hop2_code_q;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        sw        = sw_q;
        cur_state = cur_state_q;
    end

endmodule
